// File: rtl/muldiv_pkg.sv
// Shared constants and types for the multi-cycle multiply/divide sequencer.
// ALU opcodes live here so the control unit and the sequencer agree on them.
package muldiv_pkg;

    localparam int unsigned WIDTH = 8;

    localparam logic [3:0] ALU_MULTIPLY = 4'b1010;
    localparam logic [3:0] ALU_DIVIDE   = 4'b1011;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        DONE
    } state_e;

endpackage

// File: rtl/muldiv_datapath.sv
// Shared shift register datapath: shift-add multiply or restoring divide, one bit per step.
// r_lo holds multiplier/quotient, r_hi holds accumulator high part/partial remainder.
module muldiv_datapath
    import muldiv_pkg::*;
#(
    parameter int unsigned W = WIDTH
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_load,
    input  logic         i_mode_div,
    input  logic         i_step,
    input  logic [W-1:0] i_op_a,
    input  logic [W-1:0] i_op_b,
    output logic [W-1:0] o_lo_d,
    output logic [W-1:0] o_hi_d
);

    logic [W-1:0] r_lo;
    logic [W-1:0] r_b;
    logic [W:0]   r_hi;
    logic         r_div;

    logic [W-1:0] w_lo_d;
    logic [W:0]   w_hi_d;
    logic [W:0]   w_sum;
    logic [W:0]   w_shift;
    logic [W+1:0] w_diff;

    always_comb begin
        w_sum   = {1'b0, r_hi[W-1:0]} + (r_lo[0] ? {1'b0, r_b} : {(W+1){1'b0}});
        w_shift = {r_hi[W-1:0], r_lo[W-1]};
        w_diff  = {1'b0, w_shift} - {2'b00, r_b};
        w_lo_d  = r_lo;
        w_hi_d  = r_hi;
        if (i_step) begin
            if (r_div) begin
                // Restore by keeping the shifted remainder when the trial subtract borrows.
                if (!w_diff[W+1]) begin
                    w_hi_d = w_diff[W:0];
                    w_lo_d = {r_lo[W-2:0], 1'b1};
                end else begin
                    w_hi_d = w_shift;
                    w_lo_d = {r_lo[W-2:0], 1'b0};
                end
            end else begin
                w_hi_d = {1'b0, w_sum[W:1]};
                w_lo_d = {w_sum[0], r_lo[W-1:1]};
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_lo  <= '0;
            r_b   <= '0;
            r_hi  <= '0;
            r_div <= 1'b0;
        end else if (i_load) begin
            r_lo  <= i_mode_div ? i_op_a : i_op_b;
            r_b   <= i_mode_div ? i_op_b : i_op_a;
            r_hi  <= '0;
            r_div <= i_mode_div;
        end else begin
            r_lo <= w_lo_d;
            r_hi <= w_hi_d;
        end
    end

    assign o_lo_d = w_lo_d;
    assign o_hi_d = w_hi_d[W-1:0];

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MUL/DIV sequencer beside the ALU; stalls the pipeline while iterating.
// Results are captured only on entry to DONE and held until the next operation completes.
module muldiv_sequencer
    import muldiv_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [3:0]       i_alu_control,
    input  logic [WIDTH-1:0] i_op_a,
    input  logic [WIDTH-1:0] i_op_b,
    output logic [WIDTH-1:0] o_result,
    output logic [WIDTH-1:0] o_result_hi,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_div_by_zero,
    output logic             o_stall
);

    localparam int unsigned CW = $clog2(WIDTH);

    state_e           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_result_hi;
    logic             r_busy;
    logic             r_done;
    logic             r_div_by_zero;

    logic             w_is_mul;
    logic             w_is_div;
    logic             w_accept;
    logic             w_step;
    logic [WIDTH-1:0] w_lo_d;
    logic [WIDTH-1:0] w_hi_d;

    assign w_is_mul = (i_alu_control == ALU_MULTIPLY);
    assign w_is_div = (i_alu_control == ALU_DIVIDE);
    assign w_accept = (r_state == IDLE) && i_start && (w_is_mul || w_is_div);
    assign w_step   = (r_state == MUL) || (r_state == DIV);

    muldiv_datapath #(
        .W(WIDTH)
    ) u_datapath (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_load    (w_accept),
        .i_mode_div(w_is_div),
        .i_step    (w_step),
        .i_op_a    (i_op_a),
        .i_op_b    (i_op_b),
        .o_lo_d    (w_lo_d),
        .o_hi_d    (w_hi_d)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_result      <= '0;
            r_result_hi   <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_div_by_zero <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_cnt         <= '0;
                        r_div_by_zero <= 1'b0;
                        if (w_is_div && (i_op_b == '0)) begin
                            r_state       <= DONE;
                            r_done        <= 1'b1;
                            r_div_by_zero <= 1'b1;
                            r_result      <= '1;
                            r_result_hi   <= i_op_a;
                        end else begin
                            r_state <= w_is_div ? DIV : MUL;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                MUL, DIV: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        r_state     <= DONE;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_result    <= w_lo_d;
                        r_result_hi <= w_hi_d;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_result      = r_result;
    assign o_result_hi   = r_result_hi;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_div_by_zero = r_div_by_zero;
    assign o_stall       = r_busy | w_accept;

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle sequencer for the ALU's multiply (ALUControl 4'b1010) and divide (4'b1011) operations. It performs 8-bit unsigned shift-add multiply and restoring divide, one iteration per clock. While it runs, it stalls the pipeline so that the issuing instruction stays in the execute stage until the result is valid. It sits beside the single-cycle ALU and is driven by the control unit's ALUControl output.

## Interface
- WIDTH, 8, operand width; the iteration count equals WIDTH.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high.
- start  in  1  request from the execute stage; sampled only in IDLE.
- alu_control  in  4  operation select; only 4'b1010 (MUL) and 4'b1011 (DIV) are accepted.
- op_a  in  WIDTH  multiplicand or dividend.
- op_b  in  WIDTH  multiplier or divisor.
- result  out  WIDTH  MUL: low byte of the product; DIV: quotient.
- result_hi  out  WIDTH  MUL: high byte of the product; DIV: remainder.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse; result and result_hi are valid.
- div_by_zero  out  1  high with done when DIV had op_b == 0; cleared on the next accepted start.
- stall  out  1  pipeline freeze request.

## Operation
- States: IDLE, MUL, DIV, DONE.
- An accepted start is start=1 in IDLE with alu_control equal to MUL or DIV. On acceptance the block captures op_a and op_b and clears the iteration counter.
- A start with any other alu_control value is ignored; the block stays in IDLE.
- A start seen outside IDLE is ignored. No queueing.
- MUL uses an unsigned shift-add over a 16-bit accumulator. Each iteration examines one multiplier bit, LSB first. After 8 iterations: result = product[7:0], result_hi = product[15:8].
- DIV uses restoring division with a 9-bit partial remainder. Each iteration produces one quotient bit, MSB first. After 8 iterations: result = quotient, result_hi = remainder.
- DIV with op_b == 0 performs no iterations and goes IDLE→DONE. It returns result = 8'hFF, result_hi = op_a, div_by_zero = 1.
- The counter increments on each MUL/DIV cycle. The transition to DONE occurs on the cycle where counter == WIDTH-1.
- DONE→IDLE is unconditional after one cycle.
- result and result_hi hold their values until the next accepted start; they are never cleared by IDLE.
- busy = 1 in the MUL and DIV states.
- stall = busy OR (an accepted start in IDLE), combinational, so the pipeline freezes in the issue cycle itself.
- Reset, including mid-operation: state = IDLE, counter = 0, and result, result_hi, busy, done, div_by_zero, stall all = 0. Operand registers are cleared. The aborted operation produces no done.

## Timing
- Let start be accepted in cycle N.
- stall is high in cycles N..N+8 and low in N+9.
- Iterations complete on the edges ending cycles N+1..N+8.
- In cycle N+9: state is DONE, done = 1, and results are valid. The stalled instruction advances at the end of N+9 with the valid result.
- Total latency is 9 cycles from start to done.
- Divide by zero: stall is high in N only; done and div_by_zero are high in N+1.
- A start in a DONE cycle is ignored. The earliest new start is N+10, in IDLE.
- All outputs except stall are registered.

## Structure
- Shared package contents:
  - ALU_MULTIPLY = 4'b1010 and ALU_DIVIDE = 4'b1011. These are the same values the control unit uses; define them once here.
  - State enum {IDLE, MUL, DIV, DONE}.
  - WIDTH default.
- One sub-module: muldiv_datapath. It holds the accumulator and remainder shift registers and the add/subtract step. It takes mode and step-enable inputs from the FSM in muldiv_sequencer.

## Test plan
- MUL 13×11 (op_a=8'd13, op_b=8'd11) → done at N+9, result=8'h8F, result_hi=8'h00, stall high N..N+8.
- MUL 255×255 → result=8'h01, result_hi=8'hFE, div_by_zero=0.
- DIV 200/7 → result=8'h1C, result_hi=8'h04. Follow with DIV 7/200 → result=8'h00, result_hi=8'h07.
- DIV 5/0 → done and div_by_zero at N+1, result=8'hFF, result_hi=8'h05, stall high only in N. The next MUL 2×3 gives result=8'h06 and clears div_by_zero.
- Assert reset at N+4 of a MUL → all outputs 0 immediately (asynchronous), no done pulse. The next start operates normally.
- Ignored starts:
  - start with alu_control=4'b1000 → no stall, no busy.
  - start pulsed at N+3 during a DIV → original result unchanged, single done at N+9.
